// File: rtl/dut_arbiter.sv
// Two-requester round-robin front end for a start/next engine with a response
// channel and a per-transaction timeout.
module dut_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        req0_valid,
    input  logic [31:0] req0_k,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [31:0] req1_k,
    output logic        req1_ready,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err,

    output logic        EN_start,
    input  logic        RDY_start,
    output logic [31:0] next_k,
    output logic        EN_next,
    input  logic [31:0] next,
    input  logic        RDY_next,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        NEXT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;

    logic        last_id;
    logic        id_q;
    logic [31:0] k_q;
    logic [31:0] cnt;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic        any_valid;
    logic        grant_id;
    logic        accept;
    logic        start_hs;
    logic        next_hs;
    logic        timed_out;
    logic        rsp_done;
    logic        waiting;

    // With both valid, the requester not served last wins; otherwise the single
    // valid one is taken.
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? ~last_id : req1_valid;
    assign waiting   = (state == START) || (state == NEXT);

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        EN_start   = 1'b0;
        EN_next    = 1'b0;
        next_k     = '0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        start_hs   = 1'b0;
        next_hs    = 1'b0;
        timed_out  = 1'b0;
        rsp_done   = 1'b0;

        case (state)
            IDLE: begin
                // Gated by RST so nothing is acknowledged while reset is held.
                if (any_valid && !RST) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = START;
                end
            end

            START: begin
                EN_start = RDY_start;
                if (RDY_start) begin
                    start_hs  = 1'b1;
                    state_nxt = NEXT;
                end else if (cnt == TIMEOUT_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = RESP;
                end
            end

            NEXT: begin
                next_k  = k_q;
                EN_next = RDY_next;
                if (RDY_next) begin
                    next_hs   = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == TIMEOUT_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = RESP;
                end
            end

            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_id    <= 1'b1;
            id_q       <= 1'b0;
            k_q        <= '0;
            cnt        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                k_q  <= grant_id ? req1_k : req0_k;
                id_q <= grant_id;
            end

            if (accept || start_hs) begin
                cnt <= '0;
            end else if (waiting && !next_hs) begin
                cnt <= cnt + 32'd1;
            end

            if (next_hs) begin
                rsp_data_q <= next;
                rsp_err_q  <= 1'b0;
            end else if (timed_out) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end

            if (rsp_done) begin
                last_id <= id_q;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = id_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = (state != IDLE);

endmodule

// File: doc/dut_arbiter.md
DUT_ARBITER -- requirements
Module: dut_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, max cycles waited for RDY_start or RDY_next before an error response.
REQ-002 SHALL have ports:
- CLK  in  1  system clock, rising-edge
- RST  in  1  reset, asynchronous, active-high
REQ-003 SHALL have requester 0 ports:
- req0_valid  in  1  request pending
- req0_k  in  32  operand
- req0_ready  out  1  request accepted this cycle
REQ-004 SHALL have requester 1 ports: req1_valid, req1_k, req1_ready, identical to requester 0.
REQ-005 SHALL have response ports:
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_data  out  32  result
- rsp_id  out  1  requester served
- rsp_err  out  1  timeout occurred
REQ-006 SHALL have engine-side ports:
- EN_start  out  1  start method enable
- RDY_start  in  1  start method ready
- next_k  out  32  operand to engine
- EN_next  out  1  next method enable
- next  in  32  engine result
- RDY_next  in  1  next method ready
REQ-007 SHALL have busy  out  1, high in every state except IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, START, NEXT, RESP.
REQ-009 IDLE, no reqX_valid: stay in IDLE.
REQ-010 IDLE, any reqX_valid:
- grant one requester: round-robin; if both valid, the one not served last wins
- pulse that reqX_ready for one cycle
- latch reqX_k and id
- go to START
REQ-011 reqX_ready SHALL be combinational, asserted only in IDLE, at most one per cycle.
REQ-012 START: EN_start = RDY_start; when both high, go to NEXT, clear timeout counter.
REQ-013 NEXT: next_k = latched k; EN_next = RDY_next; when both high, capture next into rsp_data, rsp_err=0, go to RESP.
REQ-014 Engine handshakes: EN_start/EN_next never high while the matching RDY is low; never high outside their state.
REQ-015 next_k SHALL drive 0 outside NEXT.
REQ-016 Timeout:
- 32-bit counter increments each START/NEXT cycle without a handshake
- reaching TIMEOUT: go to RESP with rsp_data=0, rsp_err=1, no engine enable that cycle
REQ-017 RESP:
- rsp_valid=1; rsp_data, rsp_id, rsp_err stable until rsp_valid && rsp_ready
- on handshake: record last-served id, go to IDLE
REQ-018 A new request SHALL NOT be accepted in the cycle the response completes; earliest acceptance is the next IDLE cycle.
REQ-019 Minimum latency with RDY_* high and rsp_ready high: accept cycle 0, EN_start cycle 1, EN_next cycle 2, rsp_valid cycle 3, next accept cycle 4.
REQ-020 req_valid changes while busy SHALL be ignored; latched k SHALL be unaffected.

Reset
REQ-021 RST high SHALL immediately (asynchronously) force:
- state IDLE, last-served id = 1 (requester 0 wins first tie)
- timeout counter 0; rsp_data 0, rsp_id 0, rsp_err 0
- all outputs 0
REQ-022 RST asserted mid-operation SHALL abandon the transaction with no response; engine enables drop the same cycle.
REQ-023 RST deassertion SHALL take effect on the next rising CLK; first acceptance no earlier than that edge.

Verification
REQ-024 Single request: req0_k=5, RDY_* high, engine next=0x15 -> EN_start cycle 1, EN_next with next_k=5 cycle 2, rsp_valid cycle 3, rsp_data=0x15, rsp_id=0, rsp_err=0.
REQ-025 Both valid continuously after reset, k0=1, k1=2 -> service order id 0,1,0,1; next_k matches the served requester.
REQ-026 RDY_next low 10 cycles in NEXT -> EN_next stays 0 throughout; result captured on the first RDY_next high cycle.
REQ-027 TIMEOUT=8, RDY_start held low -> after 8 START cycles, rsp_valid=1, rsp_err=1, rsp_data=0, EN_start never asserted.
REQ-028 rsp_ready low 5 cycles -> rsp_valid and rsp_data held stable; req1_valid not acknowledged until after the response handshake.
REQ-029 RST pulsed in NEXT -> all outputs 0 immediately; no response issued; next request after reset served with id 0 if both valid.
